// File: rtl/cdt2_frame_pkg.sv
// Shared CDT2 frame definition: segment sizes, trailer/idle words, receiver
// states and frame_err bit positions. Used by both the packer and the unpacker.
package cdt2_frame_pkg;

   localparam int SEG0_LEN  = 17;
   localparam int SEG1_LEN  = 16;
   localparam int SEG2_LEN  = 16;
   localparam int FRAME_LEN = SEG0_LEN + SEG1_LEN + SEG2_LEN + 2;

   localparam logic [15:0] TRAILER   = 16'h5555;
   localparam logic [15:0] IDLE_WORD = 16'd999;

   localparam int ERR_W       = 3;
   localparam int ERR_TRAILER = 0;
   localparam int ERR_CRATE   = 1;
   localparam int ERR_ABORT   = 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SEG0 = 3'd1,
      ST_SEG1 = 3'd2,
      ST_SEG2 = 3'd3,
      ST_TRL  = 3'd4,
      ST_CRT  = 3'd5
   } state_t;

   // Index of the last word of the segment handled in state s.
   function automatic logic [4:0] seg_last(input state_t s);
      logic [4:0] last;
      last = '0;
      case (s)
         ST_SEG0: last = 5'(SEG0_LEN - 1);
         ST_SEG1: last = 5'(SEG1_LEN - 1);
         ST_SEG2: last = 5'(SEG2_LEN - 1);
         default: last = '0;
      endcase
      return last;
   endfunction

   // Segment number reported on data_ch for state s.
   function automatic logic [1:0] seg_ch(input state_t s);
      logic [1:0] ch;
      ch = '0;
      case (s)
         ST_SEG1: ch = 2'd1;
         ST_SEG2: ch = 2'd2;
         default: ch = 2'd0;
      endcase
      return ch;
   endfunction

endpackage

// File: rtl/cdt2_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module cdt2_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX = {W{1'b1}};
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   // Count events, holding at MAX instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (inc && (count != MAX))
         count <= count + ONE;
   end

endmodule

// File: rtl/unpacking_cdt2.sv
// CDT2 frame unpacker: splits the 51-word serial frame into three tagged
// segments, checks the trailer and recovers the crate ID.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | outside a frame, waiting for sof
// ST_SEG0 | forwarding segment 0 words (ch0)
// ST_SEG1 | forwarding segment 1 words (ch1)
// ST_SEG2 | forwarding segment 2 words (ch2)
// ST_TRL  | trailer word on the link, compared against TRAILER
// ST_CRT  | crate word on the link, frame result reported next cycle
module unpacking_cdt2
   import cdt2_frame_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in,
   input  logic        sof,
   output logic [15:0] data_out,
   output logic        data_valid,
   output logic [1:0]  data_ch,
   output logic [4:0]  data_idx,
   output logic        frame_done,
   output logic [2:0]  frame_err,
   output logic [4:0]  crate_id,
   output logic [15:0] frame_cnt,
   output logic [15:0] err_cnt
);

   state_t           state;
   logic [4:0]       word_cnt;
   logic [ERR_W-1:0] flags;

   logic             abort;
   logic             in_crt;
   logic [ERR_W-1:0] end_flags;
   logic [ERR_W-1:0] abort_flags;
   logic             frame_inc;
   logic             err_inc;

   // Frame outcome for this word; counters must step on the same edge that
   // raises frame_done so that their new values line up with the pulse.
   always_comb begin
      abort                  = sof && (state != ST_IDLE);
      in_crt                 = (state == ST_CRT);
      end_flags              = flags;
      end_flags[ERR_CRATE]   = flags[ERR_CRATE] | (in_crt && (in[15:5] != '0));
      abort_flags            = flags;
      abort_flags[ERR_ABORT] = 1'b1;
      frame_inc              = in_crt && !sof && (end_flags == '0);
      err_inc                = abort || (in_crt && !sof && (end_flags != '0));
   end

   // Frame walker; every output is registered one cycle after its word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         word_cnt   <= '0;
         flags      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         data_ch    <= '0;
         data_idx   <= '0;
         frame_done <= 1'b0;
         frame_err  <= '0;
         crate_id   <= '0;
      end else begin
         data_valid <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= '0;
         if (sof) begin
            // An unfinished frame is closed out, and this word still
            // starts the next frame in the same cycle.
            if (abort) begin
               frame_done <= 1'b1;
               frame_err  <= abort_flags;
            end
            flags      <= '0;
            data_valid <= 1'b1;
            data_out   <= in;
            data_ch    <= 2'd0;
            data_idx   <= 5'd0;
            word_cnt   <= 5'd1;
            state      <= ST_SEG0;
         end else begin
            case (state)
               ST_SEG0, ST_SEG1, ST_SEG2: begin
                  data_valid <= 1'b1;
                  data_out   <= in;
                  data_ch    <= seg_ch(state);
                  data_idx   <= word_cnt;
                  if (word_cnt == seg_last(state)) begin
                     word_cnt <= '0;
                     case (state)
                        ST_SEG0: state <= ST_SEG1;
                        ST_SEG1: state <= ST_SEG2;
                        default: state <= ST_TRL;
                     endcase
                  end else begin
                     word_cnt <= word_cnt + 5'd1;
                  end
               end
               ST_TRL: begin
                  if (in != TRAILER)
                     flags[ERR_TRAILER] <= 1'b1;
                  state <= ST_CRT;
               end
               ST_CRT: begin
                  frame_done <= 1'b1;
                  frame_err  <= end_flags;
                  if (end_flags == '0)
                     crate_id <= in[4:0];
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   cdt2_sat_counter #(.W(16)) u_frame_cnt (
      .clk   (clk),
      .rst_n (reset),
      .inc   (frame_inc),
      .count (frame_cnt)
   );

   cdt2_sat_counter #(.W(16)) u_err_cnt (
      .clk   (clk),
      .rst_n (reset),
      .inc   (err_inc),
      .count (err_cnt)
   );

endmodule

// File: tb/tb_unpacking_cdt2.sv
// Bench for unpacking_cdt2: directed frames plus randomized frames, checked
// against a frame-position reference model.
module tb_unpacking_cdt2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] in_w = '0;
   logic        sof = 1'b0;
   logic [15:0] data_out;
   logic        data_valid;
   logic [1:0]  data_ch;
   logic [4:0]  data_idx;
   logic        frame_done;
   logic [2:0]  frame_err;
   logic [4:0]  crate_id;
   logic [15:0] frame_cnt;
   logic [15:0] err_cnt;

   unpacking_cdt2 dut (
      .clk        (clk),
      .reset      (reset),
      .in         (in_w),
      .sof        (sof),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ch    (data_ch),
      .data_idx   (data_idx),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .crate_id   (crate_id),
      .frame_cnt  (frame_cnt),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state: position within frame (-1 = outside a frame)
   int          pos = -1;
   logic [2:0]  mflags = '0;
   logic [4:0]  mcrate = '0;
   logic [15:0] mfcnt = '0;
   logic [15:0] mecnt = '0;
   logic        e_valid, e_done;
   logic [15:0] e_data;
   logic [1:0]  e_ch;
   logic [4:0]  e_idx;
   logic [2:0]  e_err;

   logic [15:0] fw [51];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sat(input logic [15:0] x);
      return (x == 16'hFFFF) ? x : x + 16'd1;
   endfunction

   task automatic model_reset();
      pos = -1; mflags = '0; mcrate = '0; mfcnt = '0; mecnt = '0;
   endtask

   // Expected outputs for one link word, from the frame layout rules.
   task automatic model_word(input logic [15:0] w, input logic s);
      e_valid = 1'b0; e_done = 1'b0; e_err = '0;
      e_data = '0; e_ch = '0; e_idx = '0;
      if (s) begin
         if (pos >= 0) begin
            e_done = 1'b1;
            e_err  = mflags | 3'b100;
            mecnt  = sat(mecnt);
         end
         pos = 0;
         mflags = '0;
      end
      if (pos >= 0 && pos < 49) begin
         e_valid = 1'b1;
         e_data  = w;
         if (pos < 17) begin
            e_ch = 2'd0; e_idx = 5'(pos);
         end else if (pos < 33) begin
            e_ch = 2'd1; e_idx = 5'(pos - 17);
         end else begin
            e_ch = 2'd2; e_idx = 5'(pos - 33);
         end
         pos++;
      end else if (pos == 49) begin
         if (w != 16'h5555) mflags[0] = 1'b1;
         pos = 50;
      end else if (pos == 50) begin
         e_err  = mflags | ((w[15:5] != 11'd0) ? 3'b010 : 3'b000);
         e_done = 1'b1;
         if (e_err == 3'b000) begin
            mcrate = w[4:0];
            mfcnt  = sat(mfcnt);
         end else begin
            mecnt = sat(mecnt);
         end
         pos = -1;
      end
   endtask

   task automatic step(input logic [15:0] w, input logic s);
      in_w = w;
      sof  = s;
      @(posedge clk);
      model_word(w, s);
      #1;
      check("data_valid", 32'(data_valid), 32'(e_valid));
      if (e_valid) begin
         check("data_out", 32'(data_out), 32'(e_data));
         check("data_ch", 32'(data_ch), 32'(e_ch));
         check("data_idx", 32'(data_idx), 32'(e_idx));
      end
      check("frame_done", 32'(frame_done), 32'(e_done));
      if (e_done) check("frame_err", 32'(frame_err), 32'(e_err));
      check("crate_id", 32'(crate_id), 32'(mcrate));
      check("frame_cnt", 32'(frame_cnt), 32'(mfcnt));
      check("err_cnt", 32'(err_cnt), 32'(mecnt));
   endtask

   task automatic build(input logic [15:0] base, input logic [15:0] trl, input logic [15:0] crt);
      for (int k = 0; k < 49; k++) fw[k] = base + 16'(k);
      fw[49] = trl;
      fw[50] = crt;
   endtask

   // Drive the frame in fw; stop_at < 51 leaves it unfinished before that word.
   task automatic send(input int stop_at);
      for (int k = 0; k < 51; k++) begin
         if (k == stop_at) return;
         step(fw[k], k == 0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
      check({tag, "_data_out"}, 32'(data_out), 32'd0);
      check({tag, "_data_ch"}, 32'(data_ch), 32'd0);
      check({tag, "_data_idx"}, 32'(data_idx), 32'd0);
      check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
      check({tag, "_crate_id"}, 32'(crate_id), 32'd0);
      check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      model_reset();
      reset = 1'b1;
      repeat (3) step(16'd999, 1'b0);

      // clean frame
      build(16'h1000, 16'h5555, 16'h0013);
      send(99);
      step(16'd999, 1'b0);
      check("clean_crate", 32'(crate_id), 32'h13);
      check("clean_fcnt", 32'(frame_cnt), 32'd1);

      // bad trailer
      build(16'h1000, 16'h5554, 16'h0013);
      send(99);
      step(16'd999, 1'b0);
      check("badtrl_ecnt", 32'(err_cnt), 32'd1);
      check("badtrl_fcnt", 32'(frame_cnt), 32'd1);

      // crate reserved bits set
      build(16'h1100, 16'h5555, 16'h0033);
      send(99);
      step(16'd999, 1'b0);
      check("crtres_crate", 32'(crate_id), 32'h13);
      check("crtres_ecnt", 32'(err_cnt), 32'd2);

      // sof re-asserted at frame word 30, new frame completes cleanly
      build(16'h2000, 16'h5555, 16'h000A);
      send(30);
      build(16'h3000, 16'h5555, 16'h000A);
      send(99);
      step(16'd999, 1'b0);
      check("abort_ecnt", 32'(err_cnt), 32'd3);
      check("abort_crate", 32'(crate_id), 32'h0A);
      check("abort_fcnt", 32'(frame_cnt), 32'd2);

      // back-to-back clean frames
      build(16'h4000, 16'h5555, 16'h0005);
      send(99);
      build(16'h5000, 16'h5555, 16'h001F);
      send(99);
      step(16'd999, 1'b0);
      check("b2b_crate", 32'(crate_id), 32'h1F);
      check("b2b_fcnt", 32'(frame_cnt), 32'd4);

      // reset mid segment 1, between clock edges
      build(16'h6000, 16'h5555, 16'h0007);
      send(25);
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("midreset");
      model_reset();
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) step(16'(16'h1234 + i), 1'b0);
      build(16'h7000, 16'h5555, 16'h0009);
      send(99);
      step(16'd999, 1'b0);
      check("postreset_crate", 32'(crate_id), 32'h09);
      check("postreset_fcnt", 32'(frame_cnt), 32'd1);

      // randomized frames: corrupted trailers, reserved crate bits, aborts, gaps
      for (int f = 0; f < 40; f++) begin
         logic [15:0] trl, crt;
         int stop_at, gap;
         for (int k = 0; k < 49; k++) fw[k] = 16'($urandom);
         trl = 16'h5555;
         if ($urandom_range(0, 3) == 0) trl = trl ^ (16'd1 << $urandom_range(0, 15));
         crt = 16'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) crt = crt | (16'd1 << $urandom_range(5, 15));
         fw[49] = trl;
         fw[50] = crt;
         stop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 50)) : 99;
         send(stop_at);
         gap = (stop_at == 99) ? int'($urandom_range(0, 3)) : 0;
         for (int g = 0; g < gap; g++) step(($urandom_range(0, 1) == 0) ? 16'd999 : 16'($urandom), 1'b0);
      end
      build(16'h8000, 16'h5555, 16'h0011);
      send(99);
      repeat (2) step(16'd999, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
